// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV funct3 codes, memory ctrl codes,
// FSM state encoding and the access-size helper.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] CTRL_BYTE = 3'b000;
   localparam logic [2:0] CTRL_HALF = 3'b001;
   localparam logic [2:0] CTRL_WORD = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC0 = 2'd1,
      ACC1 = 2'd2,
      RESP = 2'd3
   } state_t;

   // Bytes touched by an access; illegal codes fall through to word size.
   function automatic logic [2:0] access_size(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: access_size = 3'd1;
         F3_H, F3_HU: access_size = 3'd2;
         default:     access_size = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load aligner: shifts a two-word window right by the byte offset
// and sign/zero extends the selected byte, half or word.
module load_extract
   import lsu_pkg::*;
(
   input  logic [63:0] data,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] ext
);

   logic [31:0] shifted;

   always_comb begin
      shifted = 32'(data >> {off, 3'b000});
      case (funct3)
         F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
         F3_W:    ext = shifted;
         F3_BU:   ext = {24'b0, shifted[7:0]};
         F3_HU:   ext = {16'b0, shifted[15:0]};
         default: ext = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Pipeline-side front end for the byte-addressable data memory: one request per
// handshake, word-aligned loads with extraction, boundary-crossing loads split in two.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int WORD_SIZE = 32,
   parameter int ADDR_BITS = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [2:0]           req_funct3,
   input  logic [WORD_SIZE-1:0] req_addr,
   input  logic [WORD_SIZE-1:0] req_wdata,
   output logic                 resp_valid,
   output logic [WORD_SIZE-1:0] resp_rdata,
   output logic                 resp_err,
   output logic                 mem_write_en,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_write_data,
   output logic [2:0]           mem_ctrl,
   input  logic [WORD_SIZE-1:0] mem_rdata
);

   if (ADDR_BITS < 3 || ADDR_BITS > WORD_SIZE) begin : g_bad_addr_bits
      $error("load_store_unit: ADDR_BITS out of range");
   end

   state_t               state, state_nxt;
   logic                 r_we;
   logic [2:0]           r_f3;
   logic [WORD_SIZE-1:0] r_addr, r_wdata, lo;
   logic [WORD_SIZE-1:0] aligned, ext;
   logic [63:0]          window;
   logic [2:0]           size;
   logic                 accept, illegal, split, done_ld;

   assign accept  = req_valid && req_ready;
   assign illegal = req_we ? (req_funct3 > F3_W)
                           : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
   assign size    = access_size(r_f3);
   assign split   = ({2'b00, r_addr[1:0]} + {1'b0, size}) > 4'd4;
   assign aligned = {r_addr[WORD_SIZE-1:2], 2'b00};

   // ACC1 sees the upper word live on mem_rdata; the lower word was captured in ACC0.
   assign window  = (state == ACC1) ? {mem_rdata, lo} : {32'b0, mem_rdata};
   assign done_ld = (state == ACC1) || (state == ACC0 && !r_we && !split);

   load_extract u_extract (
      .data   (window),
      .off    (r_addr[1:0]),
      .funct3 (r_f3),
      .ext    (ext)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, RESP: begin
            if (accept)      state_nxt = illegal ? RESP : ACC0;
            else             state_nxt = IDLE;
         end
         ACC0:    state_nxt = (!r_we && split) ? ACC1 : RESP;
         ACC1:    state_nxt = RESP;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      mem_write_en   = 1'b0;
      mem_addr       = '0;
      mem_write_data = '0;
      mem_ctrl       = CTRL_WORD;
      case (state)
         IDLE: req_ready = 1'b1;
         ACC0: begin
            if (r_we) begin
               mem_write_en   = 1'b1;
               mem_addr       = r_addr;
               mem_write_data = r_wdata;
               mem_ctrl       = r_f3;
            end else begin
               mem_addr = aligned;
            end
         end
         ACC1: mem_addr = aligned + WORD_SIZE'(4);
         RESP: begin
            req_ready  = 1'b1;
            resp_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Response fields only change on the edge that enters RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we       <= 1'b0;
         r_f3       <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         lo         <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         if (state == ACC0) lo <= mem_rdata;
         if (accept && illegal) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
         end else if (state == ACC0 && r_we) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
         end else if (done_ld) begin
            resp_rdata <= ext;
            resp_err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 1 KiB byte-addressed memory model.
module tb_load_store_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        resp_valid, resp_err, mem_write_en;
   logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_rdata;
   logic [2:0]  mem_ctrl;

   int n_vec = 0;
   int n_bad = 0;

   load_store_unit dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_ctrl(mem_ctrl), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:1023];
   logic [9:0] rd_base;
   int         nb;
   assign rd_base   = {mem_addr[9:2], 2'b00};
   assign mem_rdata = {mem[rd_base + 10'd3], mem[rd_base + 10'd2], mem[rd_base + 10'd1], mem[rd_base]};

   always @(posedge clk) begin
      if (mem_write_en) begin
         nb = (mem_ctrl == 3'b000) ? 1 : (mem_ctrl == 3'b001) ? 2 : 4;
         for (int i = 0; i < 4; i++)
            if (i < nb) mem[mem_addr[9:0] + 10'(i)] <= mem_write_data[8*i +: 8];
      end
   end

   // Observations from the most recent request issued through req().
   int          o_lat, o_nwe, o_nacc;
   logic [31:0] o_rd, o_we_addr, o_acc_addr;
   logic [2:0]  o_we_ctrl;
   logic        o_err;

   task req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
      o_lat = -1; o_nwe = 0; o_nacc = 0; o_rd = 'x; o_err = 1'bx;
      o_we_addr = 'x; o_acc_addr = 'x; o_we_ctrl = 'x;
      @(negedge clk);
      for (int w = 0; w < 20 && !req_ready; w++) @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (mem_write_en) begin
            o_nwe++; o_we_addr = mem_addr; o_we_ctrl = mem_ctrl;
         end
         if (!req_ready && !resp_valid) begin
            o_nacc++; o_acc_addr = mem_addr;
         end
         if (resp_valid) begin
            o_lat = c; o_rd = resp_rdata; o_err = resp_err;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task test_reset;
      #2;
      n_vec++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
      n_vec++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_resp_rdata: got %h want 0", resp_rdata); end
      n_vec++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_resp_err: got %b want 0", resp_err); end
      n_vec++; if (mem_write_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we: got %b want 0", mem_write_en); end
      n_vec++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
      n_vec++; if (mem_write_data !== 32'h0) begin n_bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_write_data); end
      n_vec++; if (mem_ctrl !== 3'b010) begin n_bad++; $display("FAIL rst_mem_ctrl: got %b want 010", mem_ctrl); end
      n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task test_store_load;
      req(1'b1, F3_W, 32'h40, 32'h800000FF);
      n_vec++; if (o_nwe !== 1) begin n_bad++; $display("FAIL sw_we_cycles: got %0d want 1", o_nwe); end
      n_vec++; if (o_we_ctrl !== 3'b010) begin n_bad++; $display("FAIL sw_ctrl: got %b want 010", o_we_ctrl); end
      n_vec++; if (o_lat !== 2) begin n_bad++; $display("FAIL sw_latency: got %0d want 2", o_lat); end
      n_vec++; if (o_err !== 1'b0 || o_rd !== 32'h0) begin n_bad++; $display("FAIL sw_resp: got err=%b rd=%h want 0/0", o_err, o_rd); end
      req(1'b0, F3_B, 32'h40, 32'h0);
      n_vec++; if (o_rd !== 32'hFFFFFFFF || o_lat !== 2) begin n_bad++; $display("FAIL lb_sign: got %h lat %0d want ffffffff lat 2", o_rd, o_lat); end
      req(1'b0, F3_BU, 32'h40, 32'h0);
      n_vec++; if (o_rd !== 32'h000000FF) begin n_bad++; $display("FAIL lbu_zero: got %h want 000000ff", o_rd); end
      req(1'b0, F3_H, 32'h40, 32'h0);
      n_vec++; if (o_rd !== 32'h000000FF) begin n_bad++; $display("FAIL lh_pos: got %h want 000000ff", o_rd); end
      n_vec++; if (o_nwe !== 0) begin n_bad++; $display("FAIL lh_no_write: got %0d want 0", o_nwe); end
   endtask

   task test_split;
      req(1'b1, F3_W, 32'h40, 32'h11223344);
      req(1'b1, F3_W, 32'h44, 32'h55667788);
      req(1'b0, F3_W, 32'h42, 32'h0);
      n_vec++; if (o_rd !== 32'h77881122) begin n_bad++; $display("FAIL lw_split_data: got %h want 77881122", o_rd); end
      n_vec++; if (o_lat !== 3) begin n_bad++; $display("FAIL lw_split_latency: got %0d want 3", o_lat); end
      n_vec++; if (o_nacc !== 2 || o_acc_addr !== 32'h44) begin n_bad++; $display("FAIL lw_split_acc1: got %0d cycles addr %h want 2 / 00000044", o_nacc, o_acc_addr); end
      req(1'b0, F3_HU, 32'h43, 32'h0);
      n_vec++; if (o_rd !== 32'h00008811 || o_lat !== 3) begin n_bad++; $display("FAIL lhu_split: got %h lat %0d want 00008811 lat 3", o_rd, o_lat); end
      req(1'b0, F3_H, 32'h42, 32'h0);
      n_vec++; if (o_rd !== 32'h00001122 || o_lat !== 2) begin n_bad++; $display("FAIL lh_no_split: got %h lat %0d want 00001122 lat 2", o_rd, o_lat); end
   endtask

   task test_back_to_back;
      logic [31:0] addrs [3];
      logic [31:0] exp_rd [3];
      logic [31:0] got_rd [3];
      int n_acc, n_resp, e, last_e, rdy_low;
      logic acc;
      addrs  = '{32'h40, 32'h44, 32'h48};
      exp_rd = '{32'h00000044, 32'hFFFFFF88, 32'h00000000};
      got_rd = '{32'hx, 32'hx, 32'hx};
      n_acc = 0; n_resp = 0; e = -1; last_e = -1; rdy_low = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_B; req_addr = addrs[0];
      for (int c = 0; c < 30 && n_resp < 3; c++) begin
         acc = req_valid && req_ready;
         @(posedge clk); #1;
         if (e >= 0) e++;
         if (acc) begin
            n_acc++;
            if (n_acc == 1) e = 0;
            if (n_acc < 3) req_addr = addrs[n_acc];
            else req_valid = 1'b0;
         end
         if (resp_valid) begin
            got_rd[n_resp] = resp_rdata; n_resp++; last_e = e;
         end else if (!req_ready) begin
            rdy_low++;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      n_vec++; if (n_resp !== 3 || last_e !== 5) begin n_bad++; $display("FAIL b2b_rate: got %0d resps, last at cycle %0d want 3 at 5", n_resp, last_e); end
      n_vec++; if (rdy_low !== 3) begin n_bad++; $display("FAIL b2b_ready_low: got %0d want 3", rdy_low); end
      for (int k = 0; k < 3; k++) begin
         n_vec++; if (got_rd[k] !== exp_rd[k]) begin n_bad++; $display("FAIL b2b_data%0d: got %h want %h", k, got_rd[k], exp_rd[k]); end
      end
   endtask

   task test_errors;
      req(1'b0, 3'b011, 32'h40, 32'h0);
      n_vec++; if (o_err !== 1'b1 || o_rd !== 32'h0) begin n_bad++; $display("FAIL ld_err_resp: got err=%b rd=%h want 1/0", o_err, o_rd); end
      n_vec++; if (o_lat !== 1 || o_nwe !== 0) begin n_bad++; $display("FAIL ld_err_timing: got lat %0d writes %0d want 1/0", o_lat, o_nwe); end
      req(1'b1, 3'b100, 32'h40, 32'hDEADBEEF);
      n_vec++; if (o_err !== 1'b1 || o_rd !== 32'h0) begin n_bad++; $display("FAIL st_err_resp: got err=%b rd=%h want 1/0", o_err, o_rd); end
      n_vec++; if (o_lat !== 1 || o_nwe !== 0) begin n_bad++; $display("FAIL st_err_timing: got lat %0d writes %0d want 1/0", o_lat, o_nwe); end
      req(1'b0, F3_W, 32'h40, 32'h0);
      n_vec++; if (o_rd !== 32'h11223344 || o_err !== 1'b0) begin n_bad++; $display("FAIL st_err_readback: got %h err %b want 11223344 err 0", o_rd, o_err); end
   endtask

   task test_unaligned_store;
      req(1'b1, F3_H, 32'h43, 32'h0000ABCD);
      n_vec++; if (o_nwe !== 1 || o_we_addr !== 32'h43 || o_we_ctrl !== 3'b001) begin n_bad++; $display("FAIL sh_unaligned: got %0d writes addr %h ctrl %b want 1 / 00000043 / 001", o_nwe, o_we_addr, o_we_ctrl); end
      req(1'b0, F3_BU, 32'h43, 32'h0);
      n_vec++; if (o_rd !== 32'h000000CD) begin n_bad++; $display("FAIL sh_byte_lo: got %h want 000000cd", o_rd); end
      req(1'b0, F3_BU, 32'h44, 32'h0);
      n_vec++; if (o_rd !== 32'h000000AB) begin n_bad++; $display("FAIL sh_byte_hi: got %h want 000000ab", o_rd); end
   endtask

   task test_reset_mid_split;
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h42;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (mem_addr !== 32'h44) begin n_bad++; $display("FAIL rst_split_acc1_addr: got %h want 00000044", mem_addr); end
      rst_n = 1'b0; #1;
      n_vec++; if (req_ready !== 1'b1 || mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_split_idle: got ready %b addr %h want 1 / 0", req_ready, mem_addr); end
      if (resp_valid) seen = 1'b1;
      repeat (3) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1; if (resp_valid) seen = 1'b1;
      n_vec++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_split_no_resp: got %b want 0", seen); end
      n_vec++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_split_ready: got %b want 1", req_ready); end
      req(1'b0, F3_W, 32'h40, 32'h0);
      n_vec++; if (o_rd !== 32'hCD223344 || o_lat !== 2) begin n_bad++; $display("FAIL rst_split_next_lw: got %h lat %0d want cd223344 lat 2", o_rd, o_lat); end
   endtask

   task test_reset_store;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h45; req_wdata = 32'h5A;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_vec++; if (mem_write_en !== 1'b1) begin n_bad++; $display("FAIL rst_st_acc0_we: got %b want 1", mem_write_en); end
      rst_n = 1'b0; #1;
      n_vec++; if (mem_write_en !== 1'b0) begin n_bad++; $display("FAIL rst_st_we_async: got %b want 0", mem_write_en); end
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      req(1'b0, F3_BU, 32'h45, 32'h0);
      n_vec++; if (o_rd !== 32'h00000077) begin n_bad++; $display("FAIL rst_st_byte_kept: got %h want 00000077", o_rd); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      test_reset;
      test_store_load;
      test_split;
      test_back_to_back;
      test_errors;
      test_unaligned_store;
      test_reset_mid_split;
      test_reset_store;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Pipeline-side front end for the byte-addressable data memory. It accepts one load or store request per handshake and drives the memory's write_en/addr/write_data/ctrl port. Loads are read as word-aligned words and extracted with sign or zero extension. A load that crosses a 4-byte boundary is split into two sequential word reads. It returns exactly one response per accepted request.

Parameters:
WORD_SIZE, 32, data and address width (fixed 32 for RV32).
ADDR_BITS, 10, number of low address bits the memory decodes; addresses wrap modulo 2^ADDR_BITS.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  high when a request can be accepted this cycle.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr  in  32  byte address.
req_wdata  in  32  store data, LSB-justified.
resp_valid  out  1  one-cycle pulse, one per accepted request.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  illegal funct3 for the operation; qualifies resp_valid.
mem_write_en  out  1  to memory write_en.
mem_addr  out  32  to memory addr.
mem_write_data  out  32  to memory write_data.
mem_ctrl  out  3  to memory ctrl (000 byte, 001 half, 010 word).
mem_rdata  in  32  asynchronous read data from memory.

Behaviour:
- States: IDLE, ACC0, ACC1, RESP. Reset value is IDLE.
- Reset values of outputs: resp_valid=0, resp_rdata=0, resp_err=0, mem_write_en=0, mem_addr=0, mem_write_data=0, mem_ctrl=010.
- Handshake: req_ready=1 in IDLE and in RESP, 0 in ACC0/ACC1. A request is accepted on a rising edge with req_valid && req_ready; its fields are registered and the state moves to ACC0. Back-to-back is allowed: an accept in RESP goes directly to ACC0. Peak rate is one non-split request per 2 cycles.
- Error check, evaluated at accept:
  - Load funct3 in {011, 110, 111} is illegal.
  - Store funct3 other than {000, 001, 010} is illegal.
  - Illegal requests skip to RESP with resp_err=1 and resp_rdata=0. No memory access is made.
- Store, ACC0: mem_write_en=1, mem_addr=registered addr (unaligned is allowed; the memory writes consecutive bytes), mem_ctrl=funct3, mem_write_data=wdata. Next state is RESP. The write commits on the ACC0→RESP edge. Stores are never split.
- Load, ACC0: mem_write_en=0, mem_addr={addr[31:2],2'b00}, mem_ctrl=010. Capture mem_rdata into lo at the end of the cycle.
  - Split condition: off=addr[1:0], size=1/2/4. Split if off+size>4.
  - If split, go to ACC1; otherwise go to RESP.
- Load, ACC1: mem_addr = aligned addr + 4, computed modulo 2^32; the memory wraps in ADDR_BITS. Capture hi, then go to RESP.
- Extraction: take 64-bit {hi,lo} >> (8*off), then:
  - funct3 000: sign-extend bits [7:0].
  - 001: sign-extend bits [15:0].
  - 010: pass bits [31:0].
  - 100 / 101: zero-extend.
- RESP: resp_valid=1 for exactly one cycle. resp_rdata/resp_err are registered and held until the next response. Outside RESP, mem_* outputs return to their reset values.
- Latency from accept edge to resp_valid high: 2 cycles non-split or store, 3 cycles split, 1 cycle error.
- No response backpressure; the consumer must take resp in the RESP cycle.
- rst_n low at any time, including mid-split, forces the following:
  - IDLE immediately.
  - mem_write_en=0 asynchronously.
  - The pending request is dropped with no response.
  - A store in ACC0 whose edge coincides with reset assertion does not write.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - Memory ctrl encodings CTRL_BYTE/CTRL_HALF/CTRL_WORD.
  - State encoding.
  - Function access_size(funct3).
- One combinational sub-module, load_extract: inputs {hi,lo}, off, funct3; output 32-bit extended data. It is reusable by a future fetch/cache path.

Test Plan:
- Store then load, non-split:
  - SW 0x800000FF @0x40 → mem_write_en=1 with ctrl=010 for exactly 1 cycle, then resp_valid at +2 cycles.
  - LB @0x40 → resp_rdata=0xFFFFFFFF.
  - LBU @0x40 → resp_rdata=0x000000FF.
  - LH @0x40 → resp_rdata=0x000000FF.
- Split load:
  - Setup: SW 0x11223344 @0x40 and SW 0x55667788 @0x44.
  - LW @0x42 → ACC1 visited with mem_addr=0x44, resp_rdata=0x77881122 at accept+3.
  - LHU @0x43 → 0x00008811.
- Back-to-back: req_valid held high with LB @0x40, LB @0x44, LB @0x48 → accepts on every RESP cycle, 3 responses in 6 cycles, req_ready low in each ACC0.
- Errors:
  - Load funct3=011 @0x40 → resp_err=1, resp_rdata=0 at accept+1, mem_write_en never asserted.
  - Store funct3=100 → same behaviour, and memory contents at 0x40 are unchanged on readback.
- Unaligned store: SH 0xABCD @0x43 → single write cycle with mem_addr=0x43 and ctrl=001; LBU @0x43=0xCD, LBU @0x44=0xAB.
- Reset:
  - Assert rst_n=0 during ACC1 of LW @0x42 → no resp_valid, req_ready=1 after release, next LW @0x40 responds correctly.
  - Assert rst_n=0 during ACC0 of a store → the target byte is unchanged.
